// File: rtl/timer_pkg.sv
// timer_pkg: constants shared by the timer control FSM and the countdown
// datapath. This covers the 2-bit state codes and the BCD digit limits, plus
// a per-digit clamp helper that is applied when a preset is loaded.
package timer_pkg;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Any digit above lim is saturated to lim.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction
endpackage

// File: rtl/timer_tick_gen.sv
// timer_tick_gen: free-running prescaler that emits a one-cycle tick.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   en     in   count enable
//   clr    in   synchronous clear (has priority over en)
//   tick   out  high in the cycle where the count is TICKS-1 and en is high.
//                The count wraps to 0 on that same edge.
module timer_tick_gen #(
  parameter int TICKS = 4,
  parameter int W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(TICKS - 1));
  assign tick   = en & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_cnt <= '0;
    else if (clr)  r_cnt <= '0;
    else if (en)   r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/timer_countdown.sv
// timer_countdown: BCD MM:SS countdown datapath that is driven by the timer
// state code.
//   c             in   clock, rising edge
//   r             in   asynchronous active-low reset
//   currentState  in   [1:0] 00 idle, 01 run, 10/11 pause
//   preset_min    in   [7:0] BCD minutes {tens, ones}
//   preset_sec    in   [7:0] BCD seconds {tens, ones}
//   min_bcd       out  [7:0] current minutes
//   sec_bcd       out  [7:0] current seconds
//   expired       out  sticky flag. It sets when the count is or becomes
//                      00:00 while running, and clears in idle.
//   done          out  one-cycle pulse that is raised together with expired
//   alarm         out  only present with TIMER_ALARM_EN. It toggles every
//                      half second while expired and running.
// Optional feature macro: TIMER_ALARM_EN.
module timer_countdown
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESCALE_W    = 26
) (
  input  logic       c,
  input  logic       r,
  input  logic [1:0] currentState,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       expired,
`ifdef TIMER_ALARM_EN
  output logic       alarm,
`endif
  output logic       done
);
  logic [7:0] r_min, r_sec;
  logic       r_expired, r_done;
  logic [7:0] w_min_nxt, w_sec_nxt;
  logic [7:0] w_min_ld, w_sec_ld;
  logic       w_run, w_idle, w_tick, w_zero, w_nxt_zero;

  assign w_idle = (currentState == ST_IDLE);
  // Code 11 is treated as pause, so only 01 counts as running.
  assign w_run  = (currentState == ST_RUN);

  timer_tick_gen #(.TICKS(TICKS_PER_SEC), .W(PRESCALE_W)) u_sec_tick (
    .clk(c), .rst_n(r), .en(w_run), .clr(w_idle), .tick(w_tick)
  );

  assign w_min_ld = {clamp_digit(preset_min[7:4], DIGIT_MAX),
                     clamp_digit(preset_min[3:0], DIGIT_MAX)};
  assign w_sec_ld = {clamp_digit(preset_sec[7:4], SEC_TENS_MAX),
                     clamp_digit(preset_sec[3:0], DIGIT_MAX)};

  assign w_zero = (r_min == 8'h00) && (r_sec == 8'h00);

  // BCD borrow chain. At 00:00 the count holds and does not wrap.
  always_comb begin
    w_min_nxt = r_min;
    w_sec_nxt = r_sec;
    if (w_tick && !w_zero) begin
      if (r_sec[3:0] != 4'd0) w_sec_nxt[3:0] = r_sec[3:0] - 4'd1;
      else begin
        w_sec_nxt[3:0] = DIGIT_MAX;
        if (r_sec[7:4] != 4'd0) w_sec_nxt[7:4] = r_sec[7:4] - 4'd1;
        else begin
          w_sec_nxt[7:4] = SEC_TENS_MAX;
          if (r_min[3:0] != 4'd0) w_min_nxt[3:0] = r_min[3:0] - 4'd1;
          else begin
            w_min_nxt[3:0] = DIGIT_MAX;
            w_min_nxt[7:4] = r_min[7:4] - 4'd1;
          end
        end
      end
    end
  end

  assign w_nxt_zero = (w_min_nxt == 8'h00) && (w_sec_nxt == 8'h00);

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_idle) begin
      r_min     <= w_min_ld;
      r_sec     <= w_sec_ld;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_run) begin
      r_min <= w_min_nxt;
      r_sec <= w_sec_nxt;
      if (w_nxt_zero) r_expired <= 1'b1;
      // Pulse only on the rising edge. The sticky flag blocks any re-pulse.
      r_done <= w_nxt_zero & ~r_expired;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign min_bcd = r_min;
  assign sec_bcd = r_sec;
  assign expired = r_expired;
  assign done    = r_done;

`ifdef TIMER_ALARM_EN
  logic w_half_tick, w_alarm_en, r_alarm;

  assign w_alarm_en = r_expired & w_run;

  // Held in clear until expired rises, so the phase starts from 0.
  timer_tick_gen #(.TICKS(TICKS_PER_SEC / 2), .W(PRESCALE_W)) u_half_tick (
    .clk(c), .rst_n(r), .en(w_alarm_en), .clr(~r_expired), .tick(w_half_tick)
  );

  always_ff @(posedge c or negedge r) begin
    if (!r)               r_alarm <= 1'b0;
    else if (!w_alarm_en) r_alarm <= 1'b0;
    else if (w_half_tick) r_alarm <= ~r_alarm;
  end

  assign alarm = r_alarm;
`endif
endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
- Datapath consumer of the 2-bit timer state code produced by the timer control FSM (00 idle, 01 running, 10 paused).
- Holds a BCD MM:SS countdown value:
  - loads a preset while idle;
  - decrements once per second while running;
  - freezes while paused.
- Flags expiry at 00:00. Outputs feed the display digit drivers and the alarm logic.

Parameters:
- TICKS_PER_SEC, 50000000: clock cycles per one-second decrement; minimum 2.
- PRESCALE_W, 26: prescaler width; must satisfy 2^PRESCALE_W >= TICKS_PER_SEC.

Ports:
- c  in  1  clock, rising edge.
- r  in  1  reset, asynchronous, active-low.
- currentState  in  2  timer state code from the control FSM.
- preset_min  in  8  BCD minutes {tens, ones}.
- preset_sec  in  8  BCD seconds {tens, ones}.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- expired  out  1  sticky: count reached 00:00 while running.
- done  out  1  one-cycle pulse on the rising edge of expired.
- alarm  out  1  present only with TIMER_ALARM_EN.

Behaviour:
- Reset (r low, async):
  - min_bcd = 8'h00, sec_bcd = 8'h00;
  - prescaler = 0;
  - expired = 0, done = 0, alarm = 0.
- State decode:
  - 00 IDLE;
  - 01 RUN;
  - 10 PAUSE;
  - 11 is treated exactly as PAUSE.
- IDLE:
  - every cycle, registers load the clamped preset;
  - prescaler cleared to 0;
  - expired cleared.
- Preset clamp (per digit, applied on load):
  - any digit > 9 becomes 9;
  - seconds-tens > 5 becomes 5.
- RUN:
  - prescaler increments each cycle;
  - at value TICKS_PER_SEC-1 it wraps to 0 and issues a one-second tick in that same cycle.
- Tick handling:
  - if count != 00:00, decrement with BCD borrow chain:
    - sec ones 0 -> 9, borrow;
    - sec tens 0 -> 5, borrow;
    - min ones 0 -> 9, borrow;
    - min tens decrements.
  - if count == 00:00, no change (no wrap to 99:59).
- Expiry:
  - expired is set on the clock edge where RUN is active and the count is, or becomes, 00:00;
  - a preset of 00:00 therefore expires on the first RUN cycle;
  - done is high for exactly the cycle after expired rises; never reasserts until expired has been cleared via IDLE.
- PAUSE:
  - count and prescaler hold;
  - a partial second is retained and resumes on return to RUN.
- Latency:
  - first decrement occurs TICKS_PER_SEC cycles after entering RUN from IDLE;
  - outputs are registered.
- Boundaries:
  - 99:59 preset is legal;
  - RUN -> IDLE mid-second discards the prescaler and reloads the preset;
  - async reset mid-count returns to reset values immediately;
  - preset changes during RUN/PAUSE are ignored.

Optional Feature:
- Macro: TIMER_ALARM_EN.
- Defined:
  - alarm port exists;
  - alarm toggles every TICKS_PER_SEC/2 cycles while expired = 1 and the state is RUN;
  - alarm is forced 0 otherwise, and 0 at reset;
  - it uses a separate half-second counter that starts from 0 when expired rises.
- Undefined:
  - no alarm port and no half-second counter;
  - all other behaviour identical.

Decomposition:
- Shared package timer_pkg:
  - state codes ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10;
  - BCD digit limits DIGIT_MAX = 9, SEC_TENS_MAX = 5.
  - The control FSM uses the same state constants.
- One sub-module, timer_tick_gen:
  - prescaler with enable/clear inputs;
  - one-cycle tick output;
  - parameterised by TICKS_PER_SEC.
  - Instantiated once for the seconds tick; reused for the half-second alarm timebase under TIMER_ALARM_EN.

Test Plan:
- Reset with state 01 and preset 12:34 -> all outputs 0; no decrement until r high.
- TICKS_PER_SEC=4, preset 01:00, IDLE -> RUN:
  - 4 cycles later sec_bcd=8'h59, min_bcd=8'h00;
  - after 60 ticks, expired=1, done pulses once, count stays 00:00.
- TICKS_PER_SEC=4, preset 00:05, RUN 6 cycles, PAUSE 20 cycles, RUN:
  - 00:04 at cycle 4, held through pause;
  - 00:03 after 2 more RUN cycles.
- Preset 8'hAF:8'h7C (invalid) in IDLE -> min_bcd=8'h99, sec_bcd=8'h59.
- Preset 00:00, IDLE -> RUN -> expired=1 on first RUN edge, done high next cycle; back to IDLE clears expired.
- TIMER_ALARM_EN, TICKS_PER_SEC=4, expiry -> alarm toggles every 2 cycles while RUN; 0 after moving to PAUSE.
